// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU datapath and its execution wrapper:
// opcode enum, flag struct and the buffered response record.
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_W-1:0] y;
    alu_flags_t       flags;
    alu_op_e          op;
  } alu_rsp_t;

  // Signed overflow of an addition, given the MSBs of both addends and the sum.
  function automatic logic add_ovf(logic a_msb, logic b_msb, logic y_msb);
    return (a_msb == b_msb) && (y_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_4bit_exec_if.sv
// Request/response channel pair between the ALU issuer (master) and the
// execution wrapper (slave).
interface alu_4bit_exec_if #(
  parameter int TAG_W = 4
);
  import alu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [ALU_W-1:0]     req_a;
  logic [ALU_W-1:0]     req_b;
  logic [OP_W-1:0]      req_op;
  logic [TAG_W-1:0]     req_tag;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ALU_W-1:0]     rsp_y;
  logic                 rsp_carry;
  logic                 rsp_overflow;
  logic                 rsp_zero;
  logic [OP_W-1:0]      rsp_op;
  logic [TAG_W-1:0]     rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_carry, rsp_overflow, rsp_zero,
           rsp_op, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_carry, rsp_overflow, rsp_zero,
           rsp_op, rsp_tag
  );

endinterface

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU: eight operations producing Y plus carry,
// signed-overflow (ADD/SUB only) and zero flags.
module alu_4bit
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_op_e          op,
  output logic [ALU_W-1:0] y,
  output alu_flags_t       flags
);

  logic [ALU_W-1:0] b_eff;
  logic [ALU_W:0]   sum;

  // SUB reuses the adder as A + ~B + 1, so carry out means "no borrow".
  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, (op == OP_SUB)};
  end

  always_comb begin
    y     = '0;
    flags = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        y              = sum[ALU_W-1:0];
        flags.carry    = sum[ALU_W];
        flags.overflow = add_ovf(a[ALU_W-1], b_eff[ALU_W-1], sum[ALU_W-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y           = {a[ALU_W-2:0], 1'b0};
        flags.carry = a[ALU_W-1];
      end
      OP_SHR: begin
        y           = {1'b0, a[ALU_W-1:1]};
        flags.carry = a[0];
      end
      default: y = '0;
    endcase
    flags.zero = (y == '0);
  end

endmodule

// File: rtl/alu_4bit_exec.sv
// Valid/ready execution wrapper around alu_4bit with a 2-entry in-order
// response buffer. Optional saturating op/overflow counters: ALU_EXEC_STATS_EN.
module alu_4bit_exec
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_4bit_exec_if.slave       bus
`ifdef ALU_EXEC_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_ovf
`endif
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [1:0]       count_reg, count_next;
  logic             wr_ptr_reg, wr_ptr_next;
  logic             rd_ptr_reg, rd_ptr_next;
  alu_rsp_t         head_reg, head_next;
  logic [TAG_W-1:0] head_tag_reg, head_tag_next;

  logic             req_ready_int, rsp_valid_int;
  logic             push, pop;
  logic [ALU_W-1:0] alu_y;
  alu_flags_t       alu_flags;
  alu_rsp_t         new_ent, other_ent;
  logic [TAG_W-1:0] other_tag;

  alu_4bit u_alu (
    .a     (bus.req_a),
    .b     (bus.req_b),
    .op    (alu_op_e'(bus.req_op)),
    .y     (alu_y),
    .flags (alu_flags)
  );

  always_comb begin
    req_ready_int = (count_reg < DEPTH_C);
    rsp_valid_int = (count_reg != 2'd0);
    push          = bus.req_valid && req_ready_int;
    pop           = rsp_valid_int && bus.rsp_ready;
    new_ent       = '{y: alu_y, flags: alu_flags, op: alu_op_e'(bus.req_op)};
  end

  // Storage slots, written at the write pointer on each accepted request.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_ent
    alu_rsp_t         ent_reg;
    logic [TAG_W-1:0] tag_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ent_reg <= '0;
        tag_reg <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        ent_reg <= new_ent;
        tag_reg <= bus.req_tag;
      end
    end
  end

  // Entry behind the current head, i.e. the one that becomes head on a pop.
  always_comb begin
    other_ent = rd_ptr_reg ? g_ent[0].ent_reg : g_ent[1].ent_reg;
    other_tag = rd_ptr_reg ? g_ent[0].tag_reg : g_ent[1].tag_reg;
  end

  // The head is kept in its own register so outputs hold their last value
  // once the buffer drains instead of showing a stale slot.
  always_comb begin
    count_next    = count_reg;
    wr_ptr_next   = wr_ptr_reg ^ push;
    rd_ptr_next   = rd_ptr_reg ^ pop;
    head_next     = head_reg;
    head_tag_next = head_tag_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
    if (pop) begin
      if (count_reg == 2'd2) begin
        head_next     = other_ent;
        head_tag_next = other_tag;
      end else if (push) begin
        head_next     = new_ent;
        head_tag_next = bus.req_tag;
      end
    end else if (push && (count_reg == 2'd0)) begin
      head_next     = new_ent;
      head_tag_next = bus.req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg    <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      head_reg     <= '0;
      head_tag_reg <= '0;
    end else begin
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      head_reg     <= head_next;
      head_tag_reg <= head_tag_next;
    end
  end

  assign bus.req_ready    = req_ready_int;
  assign bus.rsp_valid    = rsp_valid_int;
  assign bus.rsp_y        = head_reg.y;
  assign bus.rsp_carry    = head_reg.flags.carry;
  assign bus.rsp_overflow = head_reg.flags.overflow;
  assign bus.rsp_zero     = head_reg.flags.zero;
  assign bus.rsp_op       = head_reg.op;
  assign bus.rsp_tag      = head_tag_reg;

`ifdef ALU_EXEC_STATS_EN
  logic [15:0] stat_ops_reg, stat_ovf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops_reg <= '0;
      stat_ovf_reg <= '0;
    end else if (push) begin
      if (stat_ops_reg != 16'hFFFF) stat_ops_reg <= stat_ops_reg + 16'd1;
      if (alu_flags.overflow && (stat_ovf_reg != 16'hFFFF))
        stat_ovf_reg <= stat_ovf_reg + 16'd1;
    end
  end

  assign stat_ops = stat_ops_reg;
  assign stat_ovf = stat_ovf_reg;
`endif

endmodule

// File: tb/tb_alu_4bit_exec.sv
// Self-checking bench for alu_4bit_exec: directed test-plan steps followed by
// randomized traffic against a queue-based reference model.
module tb_alu_4bit_exec;

  typedef struct packed {
    logic [3:0] y;
    logic       c;
    logic       v;
    logic       z;
    logic [2:0] op;
    logic [3:0] tag;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_4bit_exec_if #(.TAG_W(4)) bif ();

`ifdef ALU_EXEC_STATS_EN
  logic [15:0] stat_ops, stat_ovf;
`endif

  alu_4bit_exec #(.DEPTH(2), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
`ifdef ALU_EXEC_STATS_EN
    ,
    .stat_ops (stat_ops),
    .stat_ovf (stat_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q[$];
  exp_t last_rsp;
  int   n_ops, n_ovf;
  bit   accepted;

  // Reference: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(int a, int b, int op, int tag);
    exp_t e;
    int   s, r, sa, sb, y;
    bit   c, v;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    c  = 0;
    v  = 0;
    y  = 0;
    case (op)
      0: begin s = a + b;            y = s % 16; c = (s > 15); r = sa + sb; v = (r > 7) || (r < -8); end
      1: begin s = a + (15 - b) + 1; y = s % 16; c = (s > 15); r = sa - sb; v = (r > 7) || (r < -8); end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = 15 - a;
      6: begin y = (a * 2) % 16; c = (a >= 8); end
      default: begin y = a / 2; c = (a % 2 == 1); end
    endcase
    e.y   = 4'(y);
    e.c   = c;
    e.v   = v;
    e.z   = (y == 0);
    e.op  = 3'(op);
    e.tag = 4'(tag);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic check_outputs();
    exp_t h;
    h = (q.size() != 0) ? q[0] : last_rsp;
    chk("rsp_valid", bif.rsp_valid, q.size() != 0);
    chk("req_ready", bif.req_ready, q.size() < 2);
    chk("rsp_y", bif.rsp_y, h.y);
    chk("rsp_carry", bif.rsp_carry, h.c);
    chk("rsp_overflow", bif.rsp_overflow, h.v);
    chk("rsp_zero", bif.rsp_zero, h.z);
    chk("rsp_op", bif.rsp_op, h.op);
    chk("rsp_tag", bif.rsp_tag, h.tag);
`ifdef ALU_EXEC_STATS_EN
    chk("stat_ops", stat_ops, n_ops);
    chk("stat_ovf", stat_ovf, n_ovf);
`endif
  endtask

  // One clock: decide handshakes from the model, advance, then compare.
  task automatic tick();
    bit   acc, pop;
    exp_t e;
    acc = bif.req_valid && (q.size() < 2);
    pop = (q.size() != 0) && bif.rsp_ready;
    e   = model(bif.req_a, bif.req_b, bif.req_op, bif.req_tag);
    @(posedge clk);
    #1;
    if (pop) begin
      last_rsp = q[0];
      void'(q.pop_front());
    end
    if (acc) begin
      q.push_back(e);
      if (n_ops < 65535) n_ops++;
      if (e.v && n_ovf < 65535) n_ovf++;
    end
    accepted = acc;
    $display("cyc: acc=%0b pop=%0b tag=%0h depth=%0d", acc, pop, bif.rsp_tag, q.size());
    check_outputs();
  endtask

  task automatic drive(input int a, input int b, input int op, input int tag);
    bif.req_valid = 1'b1;
    bif.req_a     = 4'(a);
    bif.req_b     = 4'(b);
    bif.req_op    = 3'(op);
    bif.req_tag   = 4'(tag);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bif.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    last_rsp = '0;
    n_ops    = 0;
    n_ovf    = 0;
    $display("reset applied");
    check_outputs();
  endtask

  int da[5] = '{7, 15, 0, 8, 5};
  int db[5] = '{1, 1, 1, 1, 3};
  int dop[5] = '{0, 0, 1, 1, 2};
  int dy[5] = '{8, 0, 15, 7, 1};
  int dc[5] = '{0, 1, 0, 1, 0};
  int dv[5] = '{1, 0, 0, 1, 0};
  int dz[5] = '{0, 1, 0, 0, 0};

  initial begin
    rst_n         = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_a     = '0;
    bif.req_b     = '0;
    bif.req_op    = '0;
    bif.req_tag   = '0;
    bif.rsp_ready = 1'b0;
    last_rsp      = '0;
    n_ops         = 0;
    n_ovf         = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Directed test-plan vectors, one-cycle latency, constant expectations.
    bif.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(da[i], db[i], dop[i], i + 3);
      tick();
      chk("dir_valid", bif.rsp_valid, 1);
      chk("dir_y", bif.rsp_y, dy[i]);
      chk("dir_c", bif.rsp_carry, dc[i]);
      chk("dir_v", bif.rsp_overflow, dv[i]);
      chk("dir_z", bif.rsp_zero, dz[i]);
      chk("dir_tag", bif.rsp_tag, i + 3);
      bif.req_valid = 1'b0;
      tick();
    end
`ifdef ALU_EXEC_STATS_EN
    chk("dir_stat_ops", stat_ops, 5);
    chk("dir_stat_ovf", stat_ovf, 2);
`endif

    // Backpressure: tags 1,2 fill the buffer, tag 3 waits for the first pop.
    bif.rsp_ready = 1'b0;
    drive(1, 2, 0, 1);
    tick();
    drive(3, 4, 2, 2);
    tick();
    chk("bp_full_ready", bif.req_ready, 0);
    drive(5, 6, 4, 3);
    tick();
    chk("bp_tag3_blocked", accepted, 0);
    chk("bp_head_stable", bif.rsp_tag, 1);
    bif.rsp_ready = 1'b1;
    tick();
    chk("bp_no_push_on_full_pop", accepted, 0);
    chk("bp_head_tag2", bif.rsp_tag, 2);
    tick();
    chk("bp_tag3_accepted", accepted, 1);
    chk("bp_head_tag3", bif.rsp_tag, 3);
    bif.req_valid = 1'b0;
    tick();
    chk("bp_drained", bif.rsp_valid, 0);

    // Randomized traffic; a pending request is held until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!bif.req_valid || accepted) begin
        if ($urandom_range(0, 3) != 0)
          drive($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 7), $urandom_range(0, 15));
        else
          bif.req_valid = 1'b0;
      end
      bif.rsp_ready = (i >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end

    // Reset with two entries buffered: both are discarded.
    bif.rsp_ready = 1'b0;
    drive(7, 1, 0, 9);
    tick();
    drive(8, 1, 1, 10);
    tick();
    chk("mid_full", bif.rsp_valid, 1);
    do_reset();
    chk("mid_rst_valid", bif.rsp_valid, 0);
    chk("mid_rst_ready", bif.req_ready, 1);
    bif.rsp_ready = 1'b1;
    repeat (3) tick();
    chk("mid_no_ghost", bif.rsp_valid, 0);
    drive(2, 3, 0, 6);
    tick();
    chk("post_rst_y", bif.rsp_y, 5);
    bif.req_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
